// File: rtl/ssdec_pkg.sv
// Shared types and the hex-to-seven-segment table for the display drivers.
package ssdec_pkg;

    // Segment bus ordered {g,f,e,d,c,b,a}, active-high.
    typedef logic [6:0] seg_t;

    // Hex glyphs 0..F; lower-case b and d keep them distinct from 8 and 0.
    localparam seg_t SEG7_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg_t seg_of(input logic [3:0] hex);
        return SEG7_LUT[hex];
    endfunction

endpackage

// File: rtl/ssdec.sv
// Single-digit hex to seven-segment decoder (combinational).
module ssdec
    import ssdec_pkg::*;
(
    input  logic       en,
    input  logic [3:0] hex,
    output seg_t       seg
);

    // Look up the glyph; a disabled decoder drives all segments off.
    always_comb begin
        seg = en ? seg_of(hex) : '0;
    end

endmodule

// File: rtl/ssdec_scan.sv
// Time-multiplexed N-digit seven-segment scanner with double-buffered
// value, leading-zero blanking, per-digit blink and a frame-done strobe.
module ssdec_scan
    import ssdec_pkg::*;
#(
    parameter int NDIGITS      = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic                   load,
    input  logic [NDIGITS-1:0]     digit_en,
    input  logic [NDIGITS-1:0]     dp_in,
    input  logic                   blank_lz,
    input  logic [NDIGITS-1:0]     blink_mask,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [NDIGITS-1:0]     an,
    output logic                   frame_done
);

    localparam int PW = (PRESCALE > 1)     ? $clog2(PRESCALE)     : 1;
    localparam int IW = (NDIGITS > 1)      ? $clog2(NDIGITS)      : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NDIGITS - 1);
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

    logic [4*NDIGITS-1:0] pend_q,   pend_d;
    logic                 pend_v_q, pend_v_d;
    logic [4*NDIGITS-1:0] active_q, active_d;
    logic [PW-1:0]        pcnt_q,   pcnt_d;
    logic [IW-1:0]        idx_q,    idx_d;
    logic [FW-1:0]        fcnt_q,   fcnt_d;
    logic                 bph_q,    bph_d;
    seg_t                 seg_q,    seg_d;
    logic                 dp_q,     dp_d;
    logic [NDIGITS-1:0]   an_q,     an_d;
    logic                 fd_q,     fd_d;

    logic                 tick;
    logic                 wrap;
    logic [3:0]           nib [NDIGITS];
    logic [NDIGITS-1:0]   nz_above;
    logic [NDIGITS-1:0]   blank_vec;
    logic [3:0]           sel_nib;
    logic                 sel_blank;
    logic                 sel_dp;
    seg_t                 dec_seg;

    assign tick = (pcnt_q == P_LAST);
    assign wrap = tick && (idx_q == I_LAST);

    // Split the active word into per-digit nibbles.
    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_nib
            assign nib[gi] = active_q[4*gi +: 4];
        end
    endgenerate

    // Prefix-OR from the MSB: bit k set when any digit k..N-1 is non-zero.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        nz_above = '0;
        for (int k = NDIGITS - 1; k >= 0; k--) begin
            acc         = acc | (nib[k] != 4'h0);
            nz_above[k] = acc;
        end
    end

    // Per-digit blank decision and selection of the digit being scanned.
    always_comb begin
        blank_vec = '0;
        sel_nib   = 4'h0;
        sel_blank = 1'b1;
        sel_dp    = 1'b0;
        an_d      = '0;
        for (int k = 0; k < NDIGITS; k++) begin
            blank_vec[k] = !digit_en[k]
                         || (bph_q && blink_mask[k])
                         || (blank_lz && (k != 0) && !nz_above[k]);
            if (IW'(k) == idx_q) begin
                sel_nib   = nib[k];
                sel_blank = blank_vec[k];
                sel_dp    = dp_in[k];
                an_d[k]   = 1'b1;
            end
        end
    end

    ssdec u_dec (
        .en  (1'b1),
        .hex (sel_nib),
        .seg (dec_seg)
    );

    // Next-state for counters, buffers and the registered display outputs.
    always_comb begin
        pcnt_d   = tick ? '0 : pcnt_q + PW'(1);
        idx_d    = idx_q;
        fcnt_d   = fcnt_q;
        bph_d    = bph_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        active_d = active_q;

        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IW'(1);
        end

        if (wrap) begin
            if (fcnt_q == F_LAST) begin
                fcnt_d = '0;
                bph_d  = ~bph_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        // A load on the boundary goes straight to the display buffer.
        if (wrap && load) begin
            pend_d   = value;
            active_d = value;
            pend_v_d = 1'b0;
        end else if (wrap && pend_v_q) begin
            active_d = pend_q;
            pend_v_d = 1'b0;
        end else if (load) begin
            pend_d   = value;
            pend_v_d = 1'b1;
        end

        seg_d = sel_blank ? '0 : dec_seg;
        dp_d  = !sel_blank && sel_dp;
        fd_d  = wrap;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            active_q <= '0;
            pcnt_q   <= '0;
            idx_q    <= '0;
            fcnt_q   <= '0;
            bph_q    <= 1'b0;
            seg_q    <= '0;
            dp_q     <= 1'b0;
            an_q     <= '0;
            fd_q     <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            active_q <= active_d;
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            fcnt_q   <= fcnt_d;
            bph_q    <= bph_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
            fd_q     <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_ssdec_scan.sv
// Scoreboard bench for ssdec_scan (4 digits, 4-cycle slots, 2-frame blink).
module tb_ssdec_scan;

    logic        clk = 1'b0;
    logic        nrst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    ssdec_scan #(
        .NDIGITS      (4),
        .PRESCALE     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .value      (value),
        .load       (load),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    // Edges since reset release: 0 right after the first edge with nrst high.
    int   kcnt     = -1;

    always @(posedge clk) begin
        kcnt <= nrst ? kcnt + 1 : -1;
    end

    // Monitor: compare every expectation stamped with the current cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc == kcnt) begin
            e = sb.pop_front();
            n_checks++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
                n_fail++;
                $display("FAIL scan k=%0d: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                         kcnt, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end else begin
                $display("ok   scan k=%0d an=%b seg=%b dp=%b fd=%b", kcnt, an, seg, dp, frame_done);
            end
        end
    end

    // Push one 16-cycle frame; segs packed {d3,d2,d1,d0}.
    task automatic expect_frame(input int start, input logic [27:0] segs, input logic [3:0] dpm);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            int d;
            d      = i / 4;
            e.cyc  = start + i;
            e.an   = 4'b0001 << d;
            e.seg  = segs[7*d +: 7];
            e.dp   = dpm[d];
            e.fd   = (i == 15);
            sb.push_back(e);
        end
    endtask

    task automatic expect_reset();
        exp_t e;
        e.cyc = -1;
        e.an  = '0;
        e.seg = '0;
        e.dp  = 1'b0;
        e.fd  = 1'b0;
        sb.push_back(e);
    endtask

    task automatic wait_k(input int target);
        while (kcnt < target) @(negedge clk);
    endtask

    task automatic check_pend_v(input logic want);
        n_checks++;
        if (dut.pend_v_q !== want) begin
            n_fail++;
            $display("FAIL pend_v k=%0d: got %b, want %b", kcnt, dut.pend_v_q, want);
        end else begin
            $display("ok   pend_v k=%0d = %b", kcnt, dut.pend_v_q);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Directed stimulus; expectations are pushed ahead of the cycles they cover.
    initial begin
        nrst       = 1'b0;
        value      = 16'h0000;
        load       = 1'b0;
        digit_en   = 4'hF;
        dp_in      = 4'b0010;
        blank_lz   = 1'b0;
        blink_mask = 4'b0000;
        expect_reset();
        repeat (3) @(negedge clk);

        // Scan of the reset value, two frames.
        expect_frame(0,  {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0010);
        expect_frame(16, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0010);
        nrst = 1'b1;

        // Mid-frame load: frame 1 unchanged, frame 2 shows 12A0.
        wait_k(20);
        value = 16'h12A0;
        load  = 1'b1;
        expect_frame(32, {7'h06, 7'h5B, 7'h77, 7'h3F}, 4'b0010);
        wait_k(21);
        load = 1'b0;
        check_pend_v(1'b1);

        // Leading-zero blanking of 0050 then 0000.
        wait_k(40);
        value = 16'h0050;
        load  = 1'b1;
        expect_frame(48, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0010);
        wait_k(41);
        load = 1'b0;
        wait_k(47);
        blank_lz = 1'b1;
        wait_k(52);
        value = 16'h0000;
        load  = 1'b1;
        expect_frame(64, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000);
        wait_k(53);
        load = 1'b0;

        // Blink on digit 0: shown in frame 5, blank in 6 and 7.
        wait_k(70);
        value = 16'h4321;
        load  = 1'b1;
        expect_frame(80,  {7'h66, 7'h4F, 7'h5B, 7'h06}, 4'b0010);
        expect_frame(96,  {7'h66, 7'h4F, 7'h5B, 7'h00}, 4'b0010);
        expect_frame(112, {7'h66, 7'h4F, 7'h5B, 7'h00}, 4'b0010);
        wait_k(71);
        load = 1'b0;
        wait_k(79);
        blank_lz   = 1'b0;
        blink_mask = 4'b0001;

        // Frame 8: blink back on, digit 1 disabled (seg and dp low).
        wait_k(127);
        digit_en = 4'b1101;
        expect_frame(128, {7'h66, 7'h4F, 7'h00, 7'h06}, 4'b0000);

        // Load on the boundary edge goes straight to the next frame.
        wait_k(142);
        digit_en = 4'hF;
        value    = 16'hBEEF;
        load     = 1'b1;
        expect_frame(144, {7'h7C, 7'h79, 7'h79, 7'h71}, 4'b0010);
        wait_k(143);
        load = 1'b0;
        check_pend_v(1'b0);

        // Pending value dropped by a mid-slot reset.
        wait_k(165);
        value = 16'h7777;
        load  = 1'b1;
        wait_k(166);
        load = 1'b0;
        check_pend_v(1'b1);
        wait_k(169);
        expect_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        expect_frame(0,  {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0010);
        expect_frame(16, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0010);
        nrst = 1'b1;

        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
